// File: rtl/seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Brief    : Multi-cycle restoring divider, one quotient bit per cycle,
//            unsigned or signed operands, valid/ready on both sides.
//            Divide-by-zero and signed overflow return fixed, flagged results.
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider #(
  parameter  int N  = 8,
  localparam int CW = $clog2(N+1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         is_signed,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         dbz,
  output logic         ovf
);

  localparam logic [N-1:0] c_ONES = {N{1'b1}};
  localparam logic [N-1:0] c_MIN  = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_CALC = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t r_state;
  state_t w_next;

  // Latched operands
  logic [N-1:0]  r_a;
  logic [N-1:0]  r_b;
  logic          r_signed;
  // Iteration datapath: r_qmag starts as the dividend magnitude and is
  // shifted out MSB first while quotient bits are shifted in at the LSB.
  logic [N-1:0]  r_qmag;
  logic [N-1:0]  r_bmag;
  logic [N-1:0]  r_prem;
  logic [CW-1:0] r_cnt;
  logic          r_qneg;
  logic          r_rneg;
  // Result registers
  logic [N-1:0]  r_quo;
  logic [N-1:0]  r_rem;
  logic          r_dbz;
  logic          r_ovf;
  logic          r_out_valid;

  logic          w_a_neg;
  logic          w_b_neg;
  logic [N-1:0]  w_a_mag;
  logic [N-1:0]  w_b_mag;
  logic          w_is_dbz;
  logic          w_is_ovf;
  logic [N:0]    w_shift;
  logic [N:0]    w_diff;
  logic          w_ge;
  logic          w_last;

  // Sign and magnitude of the latched operands (signed MIN maps to 2^(N-1))
  assign w_a_neg  = r_signed & r_a[N-1];
  assign w_b_neg  = r_signed & r_b[N-1];
  assign w_a_mag  = w_a_neg ? -r_a : r_a;
  assign w_b_mag  = w_b_neg ? -r_b : r_b;
  assign w_is_dbz = (r_b == '0);
  assign w_is_ovf = r_signed && (r_a == c_MIN) && (r_b == c_ONES);

  // One restoring step: the partial remainder is always below the divisor,
  // so an N+1-bit difference is wide enough to carry a correct sign.
  assign w_shift = {r_prem, r_qmag[N-1]};
  assign w_diff  = w_shift - {1'b0, r_bmag};
  assign w_ge    = ~w_diff[N];
  assign w_last  = (r_cnt == CW'(1));

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign quotient  = r_quo;
  assign remainder = r_rem;
  assign dbz       = r_dbz;
  assign ovf       = r_ovf;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (in_valid) w_next = S_LOAD;
      S_LOAD: w_next = (w_is_dbz || w_is_ovf) ? S_DONE : S_CALC;
      S_CALC: if (w_last) w_next = S_FIX;
      S_FIX:  w_next = S_DONE;
      S_DONE: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture, iteration datapath and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_signed    <= 1'b0;
      r_qmag      <= '0;
      r_bmag      <= '0;
      r_prem      <= '0;
      r_cnt       <= '0;
      r_qneg      <= 1'b0;
      r_rneg      <= 1'b0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_dbz       <= 1'b0;
      r_ovf       <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a      <= dividend;
            r_b      <= divisor;
            r_signed <= is_signed;
          end
        end
        S_LOAD: begin
          r_qmag <= w_a_mag;
          r_bmag <= w_b_mag;
          r_qneg <= w_a_neg ^ w_b_neg;
          r_rneg <= w_a_neg;
          r_prem <= '0;
          r_cnt  <= CW'(N);
          if (w_is_dbz) begin
            r_quo       <= c_ONES;
            r_rem       <= r_a;
            r_dbz       <= 1'b1;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b1;
          end else if (w_is_ovf) begin
            r_quo       <= c_MIN;
            r_rem       <= '0;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b1;
            r_out_valid <= 1'b1;
          end
        end
        S_CALC: begin
          r_prem <= w_ge ? w_diff[N-1:0] : w_shift[N-1:0];
          r_qmag <= {r_qmag[N-2:0], w_ge};
          r_cnt  <= r_cnt - CW'(1);
        end
        S_FIX: begin
          r_quo       <= r_qneg ? -r_qmag : r_qmag;
          r_rem       <= r_rneg ? -r_prem : r_prem;
          r_dbz       <= 1'b0;
          r_ovf       <= 1'b0;
          r_out_valid <= 1'b1;
        end
        S_DONE: begin
          if (out_ready) r_out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_divider
// Brief    : Scoreboard bench for seq_divider (N=8): directed vectors push
//            expected results, a monitor pops and compares on each output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_divider;

  localparam int N = 8;

  typedef struct packed {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dz;
    logic         ov;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         is_signed;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         dbz;
  logic         ovf;

  int   checks = 0;
  int   errors = 0;
  exp_t sb_q[$];

  seq_divider #(.N(N)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .dbz       (dbz),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every presented result is matched against the oldest expectation
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got q=0x%0h r=0x%0h expected no result", quotient, remainder);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("quotient",  32'(quotient),  32'(e.q));
        check("remainder", 32'(remainder), 32'(e.r));
        check("dbz",       32'(dbz),       32'(e.dz));
        check("ovf",       32'(ovf),       32'(e.ov));
      end
    end
  end

  // Issue one operation; called and returning at posedge+1.
  // Latency = rising edges after the accepting edge until out_valid is seen.
  // Normal ops: LOAD + N CALC + FIX = N+2 edges. Fast ops: LOAD goes straight
  // to DONE, so out_valid is already up no later than 2 edges after accept.
  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b, input logic s,
                       input logic [N-1:0] eq, input logic [N-1:0] er,
                       input logic edz, input logic eov, input bit fast);
    int   w;
    int   lat;
    exp_t e;
    w = 0;
    while (!in_ready && w < 100) begin
      @(posedge clk); #1;
      w++;
    end
    check("in_ready_before_issue", 32'(in_ready), 32'(1));
    in_valid  = 1'b1;
    dividend  = a;
    divisor   = b;
    is_signed = s;
    @(posedge clk); #1;
    in_valid = 1'b0;
    e.q = eq; e.r = er; e.dz = edz; e.ov = eov;
    sb_q.push_back(e);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    if (fast) check("fast_latency_le2", 32'(lat >= 1 && lat <= 2), 32'(1));
    else      check("latency", 32'(lat), 32'(N + 2));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(in_ready),  32'(1));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_quotient",  32'(quotient),  32'(0));
    check("rst_remainder", 32'(remainder), 32'(0));
    check("rst_flags",     32'({dbz, ovf}), 32'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Unsigned
    issue(8'd200, 8'd7,   1'b0, 8'd28,  8'd4,  1'b0, 1'b0, 1'b0);
    issue(8'd255, 8'd1,   1'b0, 8'd255, 8'd0,  1'b0, 1'b0, 1'b0);
    issue(8'hFF,  8'hFF,  1'b0, 8'h01,  8'h00, 1'b0, 1'b0, 1'b0);
    // Signed: -7/2, 7/-2, -128/2, -128/1, -1/-1
    issue(8'hF9,  8'h02,  1'b1, 8'hFD,  8'hFF, 1'b0, 1'b0, 1'b0);
    issue(8'h07,  8'hFE,  1'b1, 8'hFD,  8'h01, 1'b0, 1'b0, 1'b0);
    issue(8'h80,  8'h02,  1'b1, 8'hC0,  8'h00, 1'b0, 1'b0, 1'b0);
    issue(8'h80,  8'h01,  1'b1, 8'h80,  8'h00, 1'b0, 1'b0, 1'b0);
    issue(8'hFF,  8'hFF,  1'b1, 8'h01,  8'h00, 1'b0, 1'b0, 1'b0);
    // Divide by zero, unsigned and signed
    issue(8'h5A,  8'h00,  1'b0, 8'hFF,  8'h5A, 1'b1, 1'b0, 1'b1);
    issue(8'h5A,  8'h00,  1'b1, 8'hFF,  8'h5A, 1'b1, 1'b0, 1'b1);
    // Signed overflow, then the same operands unsigned
    issue(8'h80,  8'hFF,  1'b1, 8'h80,  8'h00, 1'b0, 1'b1, 1'b1);
    issue(8'h80,  8'hFF,  1'b0, 8'h00,  8'h80, 1'b0, 1'b0, 1'b0);

    // Back-pressure: 231/16 = 14 r 7 held for 5 cycles, stray request ignored
    @(posedge clk); #1;
    out_ready = 1'b0;
    issue(8'hE7, 8'h10, 1'b0, 8'h0E, 8'h07, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid  = (i == 1);
      dividend  = 8'h11;
      divisor   = 8'h01;
      is_signed = 1'b0;
      check("hold_in_ready",  32'(in_ready),  32'(0));
      check("hold_out_valid", 32'(out_valid), 32'(1));
      check("hold_quotient",  32'(quotient),  32'(8'h0E));
      check("hold_remainder", 32'(remainder), 32'(8'h07));
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_in_ready",  32'(in_ready),  32'(1));
    check("release_out_valid", 32'(out_valid), 32'(0));
    // Back-to-back: -100/7 = -14 r -2
    issue(8'h9C, 8'h07, 1'b1, 8'hF2, 8'hFE, 1'b0, 1'b0, 1'b0);

    // Reset during the 4th CALC cycle; the aborted op has no expectation
    @(posedge clk); #1;
    in_valid  = 1'b1;
    dividend  = 8'h64;
    divisor   = 8'h03;
    is_signed = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(out_valid), 32'(0));
    check("abort_in_ready",  32'(in_ready),  32'(1));
    check("abort_quotient",  32'(quotient),  32'(0));
    check("abort_remainder", 32'(remainder), 32'(0));
    check("abort_flags",     32'({dbz, ovf}), 32'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    issue(8'd100, 8'd9, 1'b0, 8'd11, 8'd1, 1'b0, 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    check("scoreboard_empty", 32'(sb_q.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
